// File: rtl/ternary_alu_sched.sv
// ternary_alu_sched: trit-serial ternary ALU (min/max/consensus/any) shared by two round-robin requesters.
// Optional TERNARY_SCHED_PERF_EN adds per-requester saturating completed-response counters.
module ternary_alu_sched #(
  parameter int TRITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [1:0]         req0_op,
  input  logic [2*TRITS-1:0] req0_a,
  input  logic [2*TRITS-1:0] req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [1:0]         req1_op,
  input  logic [2*TRITS-1:0] req1_a,
  input  logic [2*TRITS-1:0] req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*TRITS-1:0] rsp_data,
  output logic               rsp_err
`ifdef TERNARY_SCHED_PERF_EN
  ,
  output logic [15:0]        done_cnt0,
  output logic [15:0]        done_cnt1
`endif
);
  localparam int W = 2 * TRITS;
  localparam int IW = TRITS > 1 ? $clog2(TRITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(TRITS - 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          state;
  logic            last_grant;
  logic            grant;
  logic [1:0]      op_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [IW-1:0]   idx;
  logic [1:0]      a_t;
  logic [1:0]      b_t;
  logic [1:0]      f_t;
  logic [2:0]      sum;
  logic            bad;
  // Round-robin pick; only meaningful while in IDLE, where ready is gated
  always_comb begin
    grant = (req0_valid & req1_valid) ? ~last_grant : ~req0_valid;
    req0_ready = rst_n & (state == IDLE) & req0_valid & ~grant;
    req1_ready = rst_n & (state == IDLE) & req1_valid & grant;
  end
  // Current trit pair and the selected ternary function of it
  always_comb begin
    a_t = a_r[2*idx +: 2];
    b_t = b_r[2*idx +: 2];
    sum = {1'b0, a_t} + {1'b0, b_t};
    bad = (&a_t) | (&b_t);
    f_t = op_r == 2'd0 ? (a_t < b_t ? a_t : b_t) :
          op_r == 2'd1 ? (a_t > b_t ? a_t : b_t) :
          op_r == 2'd2 ? (a_t == b_t ? a_t : 2'd1) :
          (sum <= 3'd1 ? 2'd0 : sum == 3'd2 ? 2'd1 : 2'd2);
  end
  // Accept, serial evaluation and response-hold state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_r       <= 2'd0;
      a_r        <= '0;
      b_r        <= '0;
      idx        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0_ready | req1_ready) begin
          op_r       <= grant ? req1_op : req0_op;
          a_r        <= grant ? req1_a : req0_a;
          b_r        <= grant ? req1_b : req0_b;
          rsp_id     <= grant;
          last_grant <= grant;
          idx        <= '0;
          rsp_err    <= 1'b0;
          rsp_data   <= '0;
          state      <= BUSY;
        end
        BUSY: begin
          rsp_data[2*idx +: 2] <= bad ? 2'd0 : f_t;
          if (bad) rsp_err <= 1'b1;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
          end
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef TERNARY_SCHED_PERF_EN
  // Saturating count of completed response handshakes per requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt0 <= '0;
      done_cnt1 <= '0;
    end else if (rsp_valid & rsp_ready) begin
      if (!rsp_id && !(&done_cnt0)) done_cnt0 <= done_cnt0 + 1'b1;
      if (rsp_id && !(&done_cnt1)) done_cnt1 <= done_cnt1 + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_ternary_alu_sched.sv
// tb_ternary_alu_sched: directed self-checking bench for ternary_alu_sched with TRITS=4.
module tb_ternary_alu_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op = 2'd0, req1_op = 2'd0;
  logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err;
  logic [7:0] rsp_data;
`ifdef TERNARY_SCHED_PERF_EN
  logic [15:0] done_cnt0, done_cnt1;
`endif
  int compared = 0;
  int mismatched = 0;

  ternary_alu_sched #(.TRITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
`ifdef TERNARY_SCHED_PERF_EN
    , .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Drives one req0 command, waits (bounded) for its response and completes the handshake.
  task automatic do_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] d, output logic e, output logic id, output int lat);
    int n;
    n = 0;
    req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    while (!req0_ready && n < 20) begin @(posedge clk); #1; n++; end
    compared++;
    if (req0_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL accept_timeout: req0_ready=%b required 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    d = rsp_data; e = rsp_err; id = rsp_id;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (rsp_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b required 0", rsp_valid); end
    compared++; if (rsp_data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h required 00", rsp_data); end
    compared++; if ({rsp_id, rsp_err} !== 2'b00) begin mismatched++; $display("FAIL reset_id_err: got %b required 00", {rsp_id, rsp_err}); end
    compared++; if ({req0_ready, req1_ready} !== 2'b00) begin mismatched++; $display("FAIL reset_ready: got %b required 00", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ops;
    logic [7:0] exp_d [4];
    logic [7:0] d;
    logic e, id;
    int lat;
    exp_d[0] = 8'h50; exp_d[1] = 8'h9A; exp_d[2] = 8'h55; exp_d[3] = 8'h95;
    for (int i = 0; i < 4; i++) begin
      do_cmd(2'(i), 8'h92, 8'h58, d, e, id, lat);
      compared++; if (d !== exp_d[i]) begin mismatched++; $display("FAIL op%0d_data: got %h required %h", i, d, exp_d[i]); end
      compared++; if ({e, id} !== 2'b00) begin mismatched++; $display("FAIL op%0d_err_id: got %b required 00", i, {e, id}); end
      compared++; if (lat !== 4) begin mismatched++; $display("FAIL op%0d_latency: got %0d required 4", i, lat); end
    end
  endtask

  task automatic test_err;
    logic [7:0] d;
    logic e, id;
    int lat;
    do_cmd(2'd1, 8'h03, 8'h00, d, e, id, lat);
    compared++; if (d !== 8'h00) begin mismatched++; $display("FAIL err_data: got %h required 00", d); end
    compared++; if (e !== 1'b1) begin mismatched++; $display("FAIL err_flag: got %b required 1", e); end
    do_cmd(2'd1, 8'h00, 8'h00, d, e, id, lat);
    compared++; if (e !== 1'b0) begin mismatched++; $display("FAIL err_cleared: got %b required 0", e); end
  endtask

  task automatic test_alternate;
    logic [2:0] ids;
    int cyc [3];
    int seen, t;
    logic both;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    @(posedge clk); #1;
    req0_op = 2'd0; req0_a = 8'h92; req0_b = 8'h58;
    req1_op = 2'd1; req1_a = 8'h92; req1_b = 8'h58;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    seen = 0; t = 0; both = 1'b0; ids = 3'b111;
    while (seen < 3 && t < 60) begin
      @(posedge clk); #1; t++;
      if (req0_ready && req1_ready) both = 1'b1;
      if (rsp_valid) begin
        ids[seen] = rsp_id; cyc[seen] = t;
        compared++;
        if (rsp_data !== (rsp_id ? 8'h9A : 8'h50)) begin mismatched++; $display("FAIL alt_data%0d: got %h required %h", seen, rsp_data, rsp_id ? 8'h9A : 8'h50); end
        seen++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    compared++; if (seen !== 3) begin mismatched++; $display("FAIL alt_count: got %0d required 3", seen); end
    compared++; if (ids !== 3'b010) begin mismatched++; $display("FAIL alt_order: got %b required 010 (bit0 first)", ids); end
    compared++; if (both !== 1'b0) begin mismatched++; $display("FAIL alt_dual_ready: got %b required 0", both); end
    if (seen == 3) begin
      compared++; if (cyc[1] - cyc[0] !== 6 || cyc[2] - cyc[1] !== 6) begin mismatched++; $display("FAIL alt_period: got %0d,%0d required 6,6", cyc[1] - cyc[0], cyc[2] - cyc[1]); end
    end
  endtask

  task automatic test_hold;
    logic [7:0] d0;
    logic id0, unstable, rdy;
    int n;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    d0 = rsp_data; id0 = rsp_id;
    compared++; if (rsp_valid !== 1'b1) begin mismatched++; $display("FAIL hold_valid_timeout: got %b required 1", rsp_valid); end
    compared++; if (id0 !== 1'b1) begin mismatched++; $display("FAIL hold_id: got %b required 1", id0); end
    compared++; if (d0 !== 8'h9A) begin mismatched++; $display("FAIL hold_data: got %h required 9a", d0); end
    unstable = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_id !== id0) unstable = 1'b1;
      if (req0_ready || req1_ready) rdy = 1'b1;
    end
    compared++; if (unstable !== 1'b0) begin mismatched++; $display("FAIL hold_stable: got %b required 0", unstable); end
    compared++; if (rdy !== 1'b0) begin mismatched++; $display("FAIL hold_ready: got %b required 0", rdy); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    compared++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b010) begin mismatched++; $display("FAIL hold_release: valid/r0/r1 got %b required 010", {rsp_valid, req0_ready, req1_ready}); end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    compared++; if ({req0_ready, req1_ready} !== 2'b00) begin mismatched++; $display("FAIL hold_next_accept: got %b required 00", {req0_ready, req1_ready}); end
    n = 0;
    while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    compared++; if ({rsp_valid, rsp_id, rsp_data} !== {2'b10, 8'h50}) begin mismatched++; $display("FAIL hold_drain: valid/id/data got %b/%b/%h required 1/0/50", rsp_valid, rsp_id, rsp_data); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    logic e, id, stale;
    int lat, n;
    req0_op = 2'd1; req0_a = 8'h92; req0_b = 8'h58; req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (rsp_data !== 8'h0A) begin mismatched++; $display("FAIL mid_partial: got %h required 0a", rsp_data); end
    rst_n = 1'b0;
    #1;
    compared++; if ({rsp_valid, rsp_data} !== 9'h000) begin mismatched++; $display("FAIL mid_reset: valid/data got %b/%h required 0/00", rsp_valid, rsp_data); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) stale = 1'b1;
    end
    rsp_ready = 1'b0;
    compared++; if (stale !== 1'b0) begin mismatched++; $display("FAIL mid_stale: got %b required 0", stale); end
    do_cmd(2'd3, 8'h92, 8'h58, d, e, id, lat);
    compared++; if ({d, e, id} !== {8'h95, 2'b00}) begin mismatched++; $display("FAIL mid_recover: data/err/id got %h/%b/%b required 95/0/0", d, e, id); end
    compared++; if (lat !== 4) begin mismatched++; $display("FAIL mid_latency: got %0d required 4", lat); end
  endtask

  initial begin
    test_reset;
    test_ops;
    test_err;
    test_alternate;
    test_hold;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
